// File: rtl/time_sync_rx.sv
// Serial time-sync receiver: 8N1 UART bytes framed as A5 + 8-byte Unix time (MSB first),
// loaded into intertime with a one-cycle strobe. Define TIME_SYNC_CHECKSUM_EN for an XOR checksum byte.
module time_sync_rx #(
  parameter int CLK_HZ        = 50000000,
  parameter int BAUD          = 115200,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        issetintertime,
  output logic [63:0] intertime,
  output logic        frame_err,
  output logic        busy
);

  function automatic int div_round(input int num, input int den);
    return (num + den / 2) / den;
  endfunction

  localparam int DIV      = div_round(CLK_HZ, BAUD);
  localparam int HALF     = DIV / 2;
  localparam int CNT_W    = $clog2(DIV + 1);
  localparam int TO_LIMIT = TIMEOUT_BYTES * 10 * DIV;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TO_LIMIT);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

`ifdef TIME_SYNC_CHECKSUM_EN
  localparam int SHADOW_W = 64;
  typedef enum logic [1:0] {ST_WAIT_SYNC, ST_PAYLOAD, ST_CHECK, ST_LOAD} fr_state_t;
`else
  // Without a checksum the 8th byte goes straight to intertime, so only 7 bytes are held.
  localparam int SHADOW_W = 56;
  typedef enum logic [1:0] {ST_WAIT_SYNC, ST_PAYLOAD, ST_LOAD} fr_state_t;
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic                rx_meta, rx_sync, rx_prev;
  rx_state_t           rx_state, rx_state_nx;
  logic [CNT_W-1:0]    bit_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          rx_shift;
  logic                half_tick, bit_tick;
  logic                byte_vld, byte_err;
  logic [7:0]          rx_byte;

  fr_state_t           state, state_nx;
  logic [2:0]          pay_idx;
  logic [SHADOW_W-1:0] shadow;
  logic [63:0]         frame_word;
  logic [TO_W-1:0]     to_cnt;
  logic                in_frame, timeout, err_evt;
`ifdef TIME_SYNC_CHECKSUM_EN
  logic [7:0]          acc;
`endif

  // Two-flop synchronizer plus one history flop for start-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign half_tick = (bit_cnt == HALF_LAST);
  assign bit_tick  = (bit_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_nx = RX_START;
      RX_START: if (half_tick) rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (bit_tick) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE || (rx_state == RX_START && half_tick) || bit_tick)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + CNT_W'(1);
      if (rx_state == RX_START) begin
        bit_idx <= '0;
      end else if (rx_state == RX_DATA && bit_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    byte_vld = (rx_state == RX_STOP) && bit_tick && rx_sync;
    byte_err = (rx_state == RX_STOP) && bit_tick && !rx_sync;
    rx_byte  = rx_shift;
  end

  // Frame layer: the gap timer only runs between bytes of an accepted frame.
`ifdef TIME_SYNC_CHECKSUM_EN
  assign in_frame   = (state == ST_PAYLOAD) || (state == ST_CHECK);
  assign frame_word = shadow;
`else
  assign in_frame   = (state == ST_PAYLOAD);
  assign frame_word = {shadow, rx_byte};
`endif
  assign timeout = in_frame && (to_cnt == TO_MAX) && !byte_vld && !byte_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT_SYNC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_evt  = 1'b0;
    case (state)
      ST_WAIT_SYNC: begin
        if (byte_err) err_evt = 1'b1;
        else if (byte_vld && rx_byte == SYNC_BYTE) state_nx = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (byte_err || timeout) begin
          err_evt  = 1'b1;
          state_nx = ST_WAIT_SYNC;
        end else if (byte_vld && pay_idx == 3'd7) begin
`ifdef TIME_SYNC_CHECKSUM_EN
          state_nx = ST_CHECK;
`else
          state_nx = ST_LOAD;
`endif
        end
      end
`ifdef TIME_SYNC_CHECKSUM_EN
      ST_CHECK: begin
        if (byte_err || timeout || (byte_vld && rx_byte != acc)) begin
          err_evt  = 1'b1;
          state_nx = ST_WAIT_SYNC;
        end else if (byte_vld) begin
          state_nx = ST_LOAD;
        end
      end
`endif
      ST_LOAD: begin
        // Behaves like WAIT_SYNC so a byte completing here is still honoured.
        state_nx = ST_WAIT_SYNC;
        if (byte_err) err_evt = 1'b1;
        else if (byte_vld && rx_byte == SYNC_BYTE) state_nx = ST_PAYLOAD;
      end
      default: state_nx = ST_WAIT_SYNC;
    endcase
  end

  always_comb begin
    issetintertime = (state == ST_LOAD);
    busy           = (state != ST_WAIT_SYNC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_idx   <= '0;
      shadow    <= '0;
      to_cnt    <= '0;
      intertime <= '0;
      frame_err <= 1'b0;
`ifdef TIME_SYNC_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      frame_err <= err_evt;
      if (state_nx == ST_PAYLOAD && state != ST_PAYLOAD) begin
        pay_idx <= '0;
`ifdef TIME_SYNC_CHECKSUM_EN
        acc     <= '0;
`endif
      end else if (state == ST_PAYLOAD && byte_vld) begin
        shadow  <= {shadow[SHADOW_W-9:0], rx_byte};
        pay_idx <= pay_idx + 3'd1;
`ifdef TIME_SYNC_CHECKSUM_EN
        acc     <= acc ^ rx_byte;
`endif
      end
      // Load on entry so the strobe cycle already presents the new time.
      if (state_nx == ST_LOAD) intertime <= frame_word;
      if (!in_frame || byte_vld)  to_cnt <= '0;
      else if (to_cnt != TO_MAX)  to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_time_sync_rx.sv
// Randomized and directed bench for time_sync_rx, checked against a byte-level frame model.
module tb_time_sync_rx;
  localparam int CLK_HZ  = 1600000;
  localparam int BAUD    = 100000;
  localparam int TOB     = 4;
  localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TO_CLKS = TOB * 10 * DIV;
`ifdef TIME_SYNC_CHECKSUM_EN
  localparam int NREQ = 9;
`else
  localparam int NREQ = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        issetintertime;
  logic [63:0] intertime;
  logic        frame_err;
  logic        busy;

  time_sync_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BYTES(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .issetintertime(issetintertime), .intertime(intertime),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_load; logic [63:0] val;} ev_t;

  int          tests = 0;
  int          fails = 0;
  longint      cyc = 0;
  longint      last_end = 0;
  longint      last_err_cyc = 0;
  int          n_load = 0;
  int          n_err = 0;
  ev_t         exp_q[$];
  logic [7:0]  frm[$];
  bit          in_frame = 1'b0;
  logic [63:0] model_cur = 64'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit is_load, input logic [63:0] val);
    ev_t e;
    e.is_load = is_load;
    e.val     = val;
    exp_q.push_back(e);
  endtask

  // Frame-level reference: a list of accepted bytes, judged once enough have arrived.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [63:0] w;
    logic [7:0]  x;
    bit          good;
    if (!ok) begin
      in_frame = 1'b0;
      push_ev(1'b0, 64'h0);
    end else if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1'b1;
        frm.delete();
      end
    end else begin
      frm.push_back(b);
      if (frm.size() == NREQ) begin
        in_frame = 1'b0;
        w = 64'h0;
        x = 8'h0;
        for (int i = 0; i < 8; i++) begin
          w = (w << 8) | 64'(frm[i]);
          x = x ^ frm[i];
        end
        good = 1'b1;
        if (NREQ == 9) good = (frm[NREQ-1] == x);
        push_ev(good, w);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop_ok) repeat (DIV) @(negedge clk);
    last_end = cyc;
    chk("busy_after_byte", busy, in_frame);
  endtask

  task automatic idle(input int n);
    if (in_frame && n > TO_CLKS) begin
      in_frame = 1'b0;
      push_ev(1'b0, 64'h0);
    end
    repeat (n) @(negedge clk);
  endtask

  // bad_idx: payload byte (0..7) sent with a low stop bit, or -1; bad_ck corrupts the checksum.
  task automatic send_frame(input logic [63:0] v, input int bad_idx, input bit bad_ck);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h0;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      b = v[63-8*i -: 8];
      x = x ^ b;
      send_byte(b, i != bad_idx);
    end
`ifdef TIME_SYNC_CHECKSUM_EN
    send_byte(bad_ck ? (x ^ 8'h07) : x, 1'b1);
`else
    if (bad_ck) idle(1);
`endif
    idle(4);
  endtask

  task automatic rand_frame();
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h0;
    for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b, $urandom_range(0, 7) != 0);
      idle($urandom_range(0, 2 * DIV));
    end
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom);
      x = x ^ b;
      send_byte(b, $urandom_range(0, 19) != 0);
      idle($urandom_range(0, 2 * DIV));
    end
`ifdef TIME_SYNC_CHECKSUM_EN
    send_byte(($urandom_range(0, 3) == 0) ? (x ^ 8'h01) : x, 1'b1);
`endif
    idle($urandom_range(1, DIV));
  endtask

  initial begin : compare
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("strobe_err_overlap", issetintertime & frame_err, 1'b0);
        if (issetintertime || frame_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {issetintertime, frame_err}, 2'b00);
          end else begin
            e = exp_q.pop_front();
            chk("event_is_load", issetintertime, e.is_load);
            if (issetintertime) begin
              chk("intertime_on_load", intertime, e.val);
              model_cur = e.val;
              n_load++;
            end else begin
              n_err++;
              last_err_cyc = cyc;
            end
          end
        end else begin
          chk("intertime_hold", intertime, model_cur);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got %0d cycles required fewer", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int l0;
    int e0;
    repeat (3) @(negedge clk);
    chk("reset_strobe", issetintertime, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_intertime", intertime, 64'h0);
    rst_n = 1'b1;
    idle(5);

    // Reference frame with the known time value.
    l0 = n_load; e0 = n_err;
    send_frame(64'h0000_0000_66D5_B000, -1, 1'b0);
    chk("ref_load_count", n_load - l0, 1);
    chk("ref_err_count", n_err - e0, 0);
    chk("ref_intertime", intertime, 64'h0000_0000_66D5_B000);
    chk("ref_model_value", model_cur, 64'h0000_0000_66D5_B000);

`ifdef TIME_SYNC_CHECKSUM_EN
    l0 = n_load; e0 = n_err;
    send_frame(64'h0000_0000_66D5_B000, -1, 1'b1);
    chk("bad_ck_err_count", n_err - e0, 1);
    chk("bad_ck_load_count", n_load - l0, 0);
    chk("bad_ck_intertime", intertime, 64'h0000_0000_66D5_B000);
`endif

    // Leading junk, and a payload that contains the sync value.
    l0 = n_load; e0 = n_err;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_frame(64'h0123_A567_89AB_CDEF, -1, 1'b0);
    chk("junk_load_count", n_load - l0, 1);
    chk("junk_err_count", n_err - e0, 0);
    chk("junk_intertime", intertime, 64'h0123_A567_89AB_CDEF);

    // Inter-byte timeout.
    e0 = n_err;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(5 * 10 * DIV);
    chk("timeout_err_count", n_err - e0, 1);
    chk("timeout_window", (last_err_cyc - last_end >= TO_CLKS - DIV) &&
                          (last_err_cyc - last_end <= TO_CLKS + DIV), 1'b1);
    chk("timeout_busy", busy, 1'b0);
    send_frame(64'h1122_3344_5566_7788, -1, 1'b0);
    chk("after_timeout_intertime", intertime, 64'h1122_3344_5566_7788);

    // Framing error on payload byte 4.
    l0 = n_load; e0 = n_err;
    send_frame(64'hDEAD_BEEF_0BAD_F00D, 4, 1'b0);
    chk("stop_err_count", n_err - e0, 1);
    chk("stop_err_no_load", n_load - l0, 0);
    send_frame(64'h0000_0000_6000_0001, -1, 1'b0);
    chk("after_stop_err_intertime", intertime, 64'h0000_0000_6000_0001);

    // Asynchronous reset in the middle of a payload byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h77, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_strobe", issetintertime, 1'b0);
    chk("async_rst_err", frame_err, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_intertime", intertime, 64'h0);
    exp_q.delete();
    in_frame  = 1'b0;
    model_cur = 64'h0;
    uart_rx   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * DIV);
    send_frame(64'h0000_0001_2345_6789, -1, 1'b0);
    chk("after_rst_intertime", intertime, 64'h0000_0001_2345_6789);

    for (int k = 0; k < 10; k++) rand_frame();

    idle(2 * DIV);
    chk("events_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/time_sync_rx.md
TIME_SYNC_RX -- requirements
Module: time_sync_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, is the input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, is the serial bit rate.
REQ-003 Parameter TIMEOUT_BYTES, default 4, is the maximum gap between bytes, in byte times, before a frame is abandoned.
REQ-004 clk  input  1  system clock; the single clock domain.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 uart_rx  input  1  asynchronous serial line; idles high; 8N1 format, LSB first.
REQ-007 issetintertime  output  1  one-cycle load strobe to the clock core's time-set input.
REQ-008 intertime  output  64  received Unix time, registered.
REQ-009 frame_err  output  1  one-cycle pulse on any rejected byte or frame.
REQ-010 busy  output  1  high from sync-byte acceptance until frame completion or abort.

Function
REQ-011 uart_rx shall pass through a 2-flop synchronizer before any use.
REQ-012 Bit period DIV shall equal CLK_HZ/BAUD, rounded to nearest (434 at the defaults).
REQ-013 The byte receiver shall detect start on a synchronized 1->0 edge and re-check it at DIV/2; if the line is high there, the start is discarded silently.
REQ-014 The 8 data bits shall be sampled at DIV intervals after the start-bit midpoint, LSB first.
REQ-015 The stop bit shall be sampled one DIV after the last data bit; a 0 there is a framing error: byte dropped, frame_err pulsed.
REQ-016 Frame format: sync byte 0xA5, then 8 payload bytes, most significant byte first, then the optional checksum byte (see REQ-027).
REQ-017 Frame FSM states: WAIT_SYNC, PAYLOAD (byte index 0..7), CHECK (only when REQ-027 is enabled), LOAD.
REQ-018 In WAIT_SYNC, any byte other than 0xA5 shall be discarded without asserting frame_err.
REQ-019 In PAYLOAD and CHECK, 0xA5 shall be treated as data, not as a resynchronization.
REQ-020 After the last required byte is accepted and valid, the FSM enters LOAD for exactly one cycle.
  - In that cycle, intertime updates and issetintertime=1.
  - The FSM then returns to WAIT_SYNC.
REQ-021 intertime shall change only in the LOAD cycle and hold its value otherwise; payload is assembled in a separate shadow register.
REQ-022 A framing error during PAYLOAD or CHECK shall abort to WAIT_SYNC without loading.
REQ-023 An idle gap longer than TIMEOUT_BYTES*10*DIV clocks while busy shall abort to WAIT_SYNC and pulse frame_err.
REQ-024 The byte receiver shall run continuously, so a byte arriving in the LOAD cycle is not lost.
REQ-025 issetintertime and frame_err shall never be high in the same cycle.

Reset
REQ-026 On rst_n=0, asynchronously and regardless of state:
  - issetintertime=0, frame_err=0, busy=0, intertime=64'h0;
  - shadow register, counters and checksum accumulator are cleared;
  - FSM=WAIT_SYNC, byte receiver idle, synchronizer flops=1.
  Reset mid-frame discards the partial frame.

Configuration
REQ-027 Macro TIME_SYNC_CHECKSUM_EN controls the checksum byte.
  - Defined: a 10th byte equal to the XOR of the 8 payload bytes is required; on mismatch, frame_err pulses and no load occurs.
  - Undefined: LOAD follows the 8th payload byte directly, and the CHECK state and accumulator are absent.

Verification
REQ-028 Default params, send A5 00 00 00 00 66 D5 B0 00 [03 if checksum enabled] -> one issetintertime pulse; intertime=64'h0000_0000_66D5_B000; frame_err never asserted.
REQ-029 Checksum enabled, same frame with checksum 0x04 -> frame_err pulses once; no issetintertime; intertime unchanged.
REQ-030 Send 0x12, 0x34, then a valid frame -> leading bytes ignored silently; single load of the frame's value.
REQ-031 Valid sync plus 3 payload bytes, then idle for 5 byte times -> frame_err pulse about 4 byte times after the last stop bit; busy=0; a following full frame loads correctly.
REQ-032 Payload byte 4 sent with stop bit forced to 0 -> frame_err; no load; a subsequent valid frame loads.
REQ-033 Assert rst_n=0 for 3 cycles mid-payload -> all outputs zero immediately; after release, a complete frame loads normally.
